// File: rtl/gpio_defs.sv
// gpio_defs: shared GPIO constants for the switch debouncer
package gpio_defs;
  localparam int GPIO_SW_NUM          = 16;
  localparam int GPIO_SW_TICK_DIV     = 50000;
  localparam int GPIO_SW_STABLE_TICKS = 4;
endpackage

// File: rtl/gpio_sw_db_bit.sv
// gpio_sw_db_bit: per-switch debounce counter, debounced level and edge pulses
module gpio_sw_db_bit #(
  parameter int STABLE_TICKS = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic sync,
  output logic flip,
  output logic db,
  output logic rise,
  output logic fall
);
  localparam int CW = $clog2(STABLE_TICKS) + 1;
  logic [CW-1:0] cnt;
  // A new level is taken on the tick that completes the mismatch window
  assign flip = tick && (sync != db) && (cnt == CW'(STABLE_TICKS - 1));
  // Count mismatching ticks, restart on any match, invert and pulse on acceptance
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt  <= '0;
      db   <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= flip && sync;
      fall <= flip && !sync;
      cnt  <= (sync == db || flip) ? '0 : tick ? cnt + CW'(1) : cnt;
      db   <= flip ? ~db : db;
    end
endmodule

// File: rtl/gpio_sw_debounce.sv
// gpio_sw_debounce: synchronizes and debounces board switches for the GPIO block
module gpio_sw_debounce
  import gpio_defs::*;
#(
  parameter int NUM_SW       = GPIO_SW_NUM,
  parameter int TICK_DIV     = GPIO_SW_TICK_DIV,
  parameter int STABLE_TICKS = GPIO_SW_STABLE_TICKS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_SW-1:0] sw_raw_i,
  output logic [NUM_SW-1:0] gp_switch_o,
  output logic [NUM_SW-1:0] sw_rise_o,
  output logic [NUM_SW-1:0] sw_fall_o,
  output logic              sw_change_o
);
  localparam int PW = $clog2(TICK_DIV);
  logic [NUM_SW-1:0] s1, sync, flip;
  logic [PW-1:0]     pre;
  logic              tick;
  assign tick = pre == PW'(TICK_DIV - 1);
  // Two-flop synchronizer for the asynchronous switch pins
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1   <= '0;
      sync <= '0;
    end else begin
      s1   <= sw_raw_i;
      sync <= s1;
    end
  // Shared sample prescaler, wraps after TICK_DIV-1
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pre <= '0;
    else        pre <= tick ? '0 : pre + PW'(1);
  // Interrupt request, aligned with the per-bit pulses
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sw_change_o <= 1'b0;
    else        sw_change_o <= |flip;
  for (genvar i = 0; i < NUM_SW; i++) begin : g_bit
    gpio_sw_db_bit #(.STABLE_TICKS(STABLE_TICKS)) u_bit (
      .clk  (clk),
      .rst_n(rst_n),
      .tick (tick),
      .sync (sync[i]),
      .flip (flip[i]),
      .db   (gp_switch_o[i]),
      .rise (sw_rise_o[i]),
      .fall (sw_fall_o[i])
    );
  end
endmodule

// File: doc/gpio_sw_debounce.md
GPIO_SW_DEBOUNCE -- requirements
Module: gpio_sw_debounce

Interface
REQ-001 SHALL have parameter NUM_SW, default 16: number of switch inputs.
REQ-002 SHALL have parameter TICK_DIV, default 50000: clk cycles per sample tick, minimum 2.
REQ-003 SHALL have parameter STABLE_TICKS, default 4: consecutive mismatching ticks required to accept a new level, minimum 1.
REQ-004 SHALL have port clk  input  1: single clock; all flops on its rising edge.
REQ-005 SHALL have port rst_n  input  1: reset, asynchronous assert, active-low.
REQ-006 SHALL have port sw_raw_i  input  NUM_SW: raw board switch pins, asynchronous to clk.
REQ-007 SHALL have port gp_switch_o  output  NUM_SW: debounced switch levels, wired directly to gp_switch_i of the GPIO special-register block.
REQ-008 SHALL have port sw_rise_o  output  NUM_SW: 1-cycle pulse per bit on an accepted 0->1 change.
REQ-009 SHALL have port sw_fall_o  output  NUM_SW: 1-cycle pulse per bit on an accepted 1->0 change.
REQ-010 SHALL have port sw_change_o  output  1: OR of all sw_rise_o and sw_fall_o bits, for the interrupt controller.

Function
REQ-011 SHALL pass each sw_raw_i bit through a 2-flop synchronizer; only the second-stage value (sync) is used downstream.
REQ-012 SHALL run one shared prescaler counting 0..TICK_DIV-1 and wrapping to 0; tick is high for exactly the one cycle in which the count equals TICK_DIV-1.
REQ-013 SHALL keep per bit a counter cnt of width clog2(STABLE_TICKS)+1 that never wraps.
REQ-014 SHALL clear cnt to 0 in any cycle where sync equals the debounced bit, regardless of tick.
REQ-015 SHALL increment cnt on a tick cycle where sync differs from the debounced bit and cnt < STABLE_TICKS-1.
REQ-016 SHALL, on a tick cycle where sync differs and cnt == STABLE_TICKS-1, invert the debounced bit and clear cnt at the same edge.
REQ-017 SHALL register sw_rise_o/sw_fall_o at that same edge, so a pulse is coincident with the first cycle gp_switch_o shows the new value, and SHALL deassert it the following cycle.
REQ-018 SHALL register sw_change_o, coincident with the rise/fall pulses.
REQ-019 SHALL update bits independently; simultaneous flips on multiple bits in one cycle are all reported in that cycle.
REQ-020 SHALL discard a pending change that glitches back before acceptance: cnt restarts from 0 on the next mismatch.
REQ-021 SHALL accept a change between 2+(STABLE_TICKS-1)*TICK_DIV+1 and 2+STABLE_TICKS*TICK_DIV cycles after the first edge that samples a steady new raw value.
REQ-022 SHALL never generate pulses when gp_switch_o is unchanged, including at reset release.

Reset
REQ-023 SHALL, while rst_n is low, asynchronously force synchronizer flops, prescaler, all cnt, gp_switch_o, sw_rise_o, sw_fall_o and sw_change_o to 0.
REQ-024 SHALL, when reset is asserted mid-debounce, abandon the pending change; after release the bit requires a full STABLE_TICKS window from the prescaler restarting at 0.

Structure
REQ-025 SHALL take GPIO_SW_NUM and the default TICK_DIV/STABLE_TICKS constants from the shared gpio_defs package; there are no new typedefs.
REQ-026 SHALL implement per-bit logic (cnt, debounced flop, rise/fall) in one sub-module gpio_sw_db_bit, instantiated NUM_SW times by a generate loop; the synchronizer and prescaler stay in the top.

Verification (bench parameters NUM_SW=16, TICK_DIV=4, STABLE_TICKS=3)
REQ-027 SHALL cover: reset release with sw_raw_i=16'hFFFF held -> gp_switch_o=16'hFFFF within 11..14 cycles, and sw_rise_o=16'hFFFF pulsed exactly once for one cycle.
REQ-028 SHALL cover: bit 3 raised 0->1 and held -> gp_switch_o[3]=1 within 11..14 cycles; sw_rise_o=16'h0008 and sw_change_o=1 for exactly 1 cycle; sw_fall_o=0.
REQ-029 SHALL cover: bit 5 high for 6 cycles then low -> gp_switch_o stays 16'h0000 and no pulses occur.
REQ-030 SHALL cover: bits 0 and 15 changed in the same cycle -> both flip on the same edge, sw_rise_o=16'h8001, single sw_change_o pulse.
REQ-031 SHALL cover: rst_n asserted 9 cycles after a bit-2 change, released 3 cycles later with the input still high -> all outputs 0 during reset; gp_switch_o[2]=1 only 11..14 cycles after release.
REQ-032 SHALL cover: bit 7 held 1 and accepted, then dropped to 0 -> gp_switch_o[7]=0 within 11..14 cycles; sw_fall_o=16'h0080 for 1 cycle.
